// File: rtl/secded_pipe_corrector.sv
// secded_pipe_corrector
// Two-stage pipelined SEC-DED decoder for a Hamming code with an extra
// overall parity bit. The block has valid/ready streams on both sides, a
// per-word correction bypass and saturating SBE/DBE delivery counters.
//
// Code map: codeword positions 1..DATA_W+P. in_chk[i] (i<P) sits at position
// 2^i, data bits fill the non-power-of-two positions in ascending order
// (data[0] at position 3), and in_chk[P] is even parity over everything else.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake
//   in_data, in_chk, corr_en   received word, check bits, correction enable
//   out_valid/out_ready        output handshake
//   out_data                   corrected data (raw data when corr_en=0)
//   out_sbe, out_dbe           correctable / uncorrectable error flags
//   out_syndrome               P-bit Hamming syndrome
//   cnt_clr                    synchronous clear of both counters
//   sbe_cnt, dbe_cnt           saturating counts of delivered SBE/DBE words
module secded_pipe_corrector #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1, valid for DATA_W in 4..247.
    localparam int unsigned P = (DATA_W <= 4)   ? 3 :
                                (DATA_W <= 11)  ? 4 :
                                (DATA_W <= 26)  ? 5 :
                                (DATA_W <= 57)  ? 6 :
                                (DATA_W <= 120) ? 7 : 8,
    localparam int unsigned CHK_W = P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sbe,
    output logic              out_dbe,
    output logic [P-1:0]      out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sbe_cnt,
    output logic [CNT_W-1:0]  dbe_cnt
);

    // Highest codeword position, compared with one spare bit so that a
    // syndrome of 2^P-1 is still ordered correctly.
    localparam logic [P:0] LAST_POS = (P + 1)'(DATA_W + P);

    // Codeword position of data bit idx.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        pos = 3;
        for (int unsigned j = 0; j <= idx; j++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            if (j != idx) pos++;
        end
        return pos;
    endfunction

    // Data bits whose position has bit b set; they feed syndrome bit b.
    function automatic logic [DATA_W-1:0] syn_mask(input int unsigned b);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < DATA_W; j++)
            m[j] = ((data_pos(j) >> b) & 1) != 0;
        return m;
    endfunction

    logic              advance;
    logic              xfer;
    logic [P-1:0]      syn_in;
    logic              q_in;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [P-1:0]      s1_syn;
    logic              s1_q;
    logic              s1_corr;

    logic [DATA_W-1:0] fix_data;
    logic              beyond;
    logic              sbe_next;
    logic              dbe_next;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign xfer     = out_valid && out_ready;

    // Syndrome: check bit i contributes position 2^i, data bits their mask.
    for (genvar b = 0; b < P; b++) begin : g_syn
        localparam logic [DATA_W-1:0] MASK = syn_mask(b);
        assign syn_in[b] = ^(in_data & MASK) ^ in_chk[b];
    end

    assign q_in = ^in_data ^ ^in_chk;

    // A syndrome matching a data position with odd parity flips that bit;
    // check-bit positions and out-of-range syndromes never match a data bit.
    for (genvar g = 0; g < DATA_W; g++) begin : g_fix
        localparam logic [P-1:0] POS = P'(data_pos(g));
        assign fix_data[g] = s1_data[g] ^ (s1_corr && s1_q && (s1_syn == POS));
    end

    assign beyond   = {1'b0, s1_syn} > LAST_POS;
    assign sbe_next = s1_q && !beyond;
    assign dbe_next = (s1_q && beyond) || (!s1_q && (s1_syn != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_syn       <= '0;
            s1_q         <= 1'b0;
            s1_corr      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_sbe      <= 1'b0;
            out_dbe      <= 1'b0;
            out_syndrome <= '0;
        end else if (advance) begin
            s1_valid     <= in_valid;
            s1_data      <= in_data;
            s1_syn       <= syn_in;
            s1_q         <= q_in;
            s1_corr      <= corr_en;
            out_valid    <= s1_valid;
            out_data     <= fix_data;
            out_sbe      <= s1_valid && sbe_next;
            out_dbe      <= s1_valid && dbe_next;
            out_syndrome <= s1_syn;
        end
    end

    // A clear coinciding with an erroneous transfer leaves that counter at 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else begin
            if (cnt_clr)
                sbe_cnt <= CNT_W'(xfer && out_sbe);
            else if (xfer && out_sbe && !(&sbe_cnt))
                sbe_cnt <= sbe_cnt + CNT_W'(1);

            if (cnt_clr)
                dbe_cnt <= CNT_W'(xfer && out_dbe);
            else if (xfer && out_dbe && !(&dbe_cnt))
                dbe_cnt <= dbe_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_pipe_corrector.sv
// Testbench for secded_pipe_corrector (DATA_W=32, CNT_W=2).
// Expected values come from a codeword-level model: the word is unpacked
// into its positions, the syndrome is the XOR of set positions and the
// classification/correction follows the code rules directly.
module tb_secded_pipe_corrector;

    localparam int DW   = 32;
    localparam int PW   = 6;
    localparam int CW   = 7;
    localparam int N    = DW + PW;
    localparam int CMAX = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sbe;
        logic          dbe;
        logic [PW-1:0] syn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chk;
    logic          corr_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sbe;
    logic          out_dbe;
    logic [PW-1:0] out_syndrome;
    logic          cnt_clr;
    logic [1:0]    sbe_cnt;
    logic [1:0]    dbe_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int m_sbe   = 0;
    int m_dbe   = 0;

    always #5 clk = ~clk;

    secded_pipe_corrector #(.DATA_W(DW), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sbe(out_sbe), .out_dbe(out_dbe),
        .out_syndrome(out_syndrome),
        .cnt_clr(cnt_clr), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [N:0] to_cw(input logic [DW-1:0] d, input logic [CW-1:0] c);
        logic [N:0] cw;
        int j, k;
        j = 0; k = 0; cw = '0;
        cw[0] = c[PW];
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) == 0) begin cw[p] = c[k]; k++; end
            else begin cw[p] = d[j]; j++; end
        end
        return cw;
    endfunction

    function automatic logic [DW-1:0] cw_data(input logic [N:0] cw);
        logic [DW-1:0] d;
        int j;
        j = 0; d = '0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin d[j] = cw[p]; j++; end
        return d;
    endfunction

    function automatic logic [CW-1:0] cw_chk(input logic [N:0] cw);
        logic [CW-1:0] c;
        int k;
        k = 0; c = '0;
        c[PW] = cw[0];
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) == 0) begin c[k] = cw[p]; k++; end
        return c;
    endfunction

    function automatic int syn_of(input logic [N:0] cw);
        int s;
        s = 0;
        for (int p = 1; p <= N; p++)
            if (cw[p]) s = s ^ p;
        return s;
    endfunction

    function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ce);
        logic [N:0] cw;
        int   s;
        logic q;
        exp_t e;
        cw    = to_cw(d, c);
        s     = syn_of(cw);
        q     = ^cw;
        e.syn = PW'(s);
        e.d   = d;
        e.sbe = q && (s <= N);
        e.dbe = (q && (s > N)) || (!q && (s != 0));
        if (e.sbe && ce && s != 0 && (s & (s - 1)) != 0) begin
            cw[s] = ~cw[s];
            e.d   = cw_data(cw);
        end
        return e;
    endfunction

    task automatic cnt_model(input logic xfer, input logic sbe, input logic dbe, input logic clr);
        if (clr) begin
            m_sbe = (xfer && sbe) ? 1 : 0;
            m_dbe = (xfer && dbe) ? 1 : 0;
        end else begin
            if (xfer && sbe && m_sbe < CMAX) m_sbe++;
            if (xfer && dbe && m_dbe < CMAX) m_dbe++;
        end
    endtask

    // Random valid codeword with nflip bit flips (nflip<0: random check bits).
    task automatic gen_word(input int nflip, output logic [DW-1:0] d, output logic [CW-1:0] c);
        logic [N:0] cw;
        int s, p1, p2;
        d = $urandom;
        c = '0;
        s = syn_of(to_cw(d, c));
        c[PW-1:0] = PW'(s);
        c[PW] = ^to_cw(d, c);
        cw = to_cw(d, c);
        if (nflip >= 1) begin
            p1 = $urandom_range(0, N);
            cw[p1] = ~cw[p1];
        end
        if (nflip >= 2) begin
            do p2 = $urandom_range(0, N); while (p2 == p1);
            cw[p2] = ~cw[p2];
        end
        d = cw_data(cw);
        c = cw_chk(cw);
        if (nflip < 0) c = CW'($urandom);
    endtask

    // Drives one word with the output side open; returns the delivered word
    // and the number of edges from acceptance to out_valid.
    task automatic run_word(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ce,
                            output exp_t obs, output int lat);
        @(posedge clk); #1;
        out_ready = 1'b1; cnt_clr = 1'b0;
        in_valid = 1'b1; in_data = d; in_chk = c; corr_en = ce;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_chk = CW'($urandom); corr_en = ~ce;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        obs = '{d: out_data, sbe: out_sbe, dbe: out_dbe, syn: out_syndrome};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        corr_en = 1'b0; in_data = '0; in_chk = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_total++; if ({out_sbe, out_dbe, out_syndrome} !== '0)
            $display("FAIL reset_flags: got sbe=%b dbe=%b syn=%0d want 0", out_sbe, out_dbe, out_syndrome); else n_pass++;
        n_total++; if ({sbe_cnt, dbe_cnt} !== 4'b0)
            $display("FAIL reset_counters: got sbe=%0d dbe=%0d want 0", sbe_cnt, dbe_cnt); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        m_sbe = 0; m_dbe = 0;
    endtask

    // Table of directed words: clean, data[0] flip with/without correction,
    // two-bit error, overall parity bit only.
    task automatic test_directed();
        logic [DW-1:0] td [5] = '{32'h0, 32'h1, 32'h1, 32'h3, 32'h0};
        logic [CW-1:0] tc [5] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h40};
        logic          te [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int            ts [5] = '{0, 3, 3, 6, 0};
        exp_t e, obs;
        int lat;
        for (int i = 0; i < 5; i++) begin
            e = model(td[i], tc[i], te[i]);
            run_word(td[i], tc[i], te[i], obs, lat);
            n_total++; if (lat !== 2) $display("FAIL dir%0d_latency: got %0d want 2", i, lat); else n_pass++;
            n_total++; if (obs.d !== e.d) $display("FAIL dir%0d_data: got %h want %h", i, obs.d, e.d); else n_pass++;
            n_total++; if ({obs.sbe, obs.dbe} !== {e.sbe, e.dbe})
                $display("FAIL dir%0d_flags: got sbe=%b dbe=%b want sbe=%b dbe=%b", i, obs.sbe, obs.dbe, e.sbe, e.dbe); else n_pass++;
            n_total++; if (obs.syn !== PW'(ts[i])) $display("FAIL dir%0d_syndrome: got %0d want %0d", i, obs.syn, ts[i]); else n_pass++;
            cnt_model(1'b1, e.sbe, e.dbe, 1'b0);
            @(posedge clk); #1;
            n_total++; if (sbe_cnt !== 2'(m_sbe) || dbe_cnt !== 2'(m_dbe))
                $display("FAIL dir%0d_counters: got sbe=%0d dbe=%0d want sbe=%0d dbe=%0d", i, sbe_cnt, dbe_cnt, m_sbe, m_dbe); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        exp_t obs;
        int lat;
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        cnt_model(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++; if ({sbe_cnt, dbe_cnt} !== 4'b0)
            $display("FAIL clr_counters: got sbe=%0d dbe=%0d want 0", sbe_cnt, dbe_cnt); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            gen_word(1, d, c);
            run_word(d, c, 1'($urandom), obs, lat);
            cnt_model(1'b1, 1'b1, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        n_total++; if (sbe_cnt !== 2'd3) $display("FAIL sat_sbe_cnt: got %0d want 3", sbe_cnt); else n_pass++;
        gen_word(1, d, c);
        run_word(d, c, 1'b1, obs, lat);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        cnt_model(1'b1, 1'b1, 1'b0, 1'b1);
        n_total++; if (sbe_cnt !== 2'd1 || dbe_cnt !== 2'd0)
            $display("FAIL clr_with_xfer: got sbe=%0d dbe=%0d want sbe=1 dbe=0", sbe_cnt, dbe_cnt); else n_pass++;
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        exp_t e, obs;
        int lat, seen;
        @(posedge clk); #1;
        out_ready = 1'b1;
        gen_word(1, d, c);
        in_valid = 1'b1; in_data = d; in_chk = c; corr_en = 1'b1;
        @(posedge clk); #1;
        gen_word(1, d, c);
        in_data = d; in_chk = c;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_sbe = 0; m_dbe = 0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rstfl_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if ({sbe_cnt, dbe_cnt} !== 4'b0)
            $display("FAIL rstfl_counters: got sbe=%0d dbe=%0d want 0", sbe_cnt, dbe_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rstfl_in_ready: got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rstfl_ghost_words: got %0d want 0", seen); else n_pass++;
        gen_word(1, d, c);
        e = model(d, c, 1'b1);
        run_word(d, c, 1'b1, obs, lat);
        n_total++; if (lat !== 2) $display("FAIL rstfl_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if (obs !== e) $display("FAIL rstfl_word: got %h want %h", obs, e); else n_pass++;
        cnt_model(1'b1, e.sbe, e.dbe, 1'b0);
        @(posedge clk); #1;
        n_total++; if (sbe_cnt !== 2'(m_sbe) || dbe_cnt !== 2'(m_dbe))
            $display("FAIL rstfl_count_after: got sbe=%0d dbe=%0d want sbe=%0d dbe=%0d", sbe_cnt, dbe_cnt, m_sbe, m_dbe); else n_pass++;
    endtask

    // Cycle-stepped stream with scoreboard. rnd=0: saturated input with a
    // 3-cycle output stall; rnd=1: random valid, ready and counter clears.
    task automatic test_stream(input int n_words, input bit rnd, input string tag);
        exp_t q[$];
        exp_t e;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic ce, have, prev_stalled;
        logic [DW+PW+2:0] prev_out;
        int idx, cyc, ndel, k;
        idx = 0; cyc = 0; ndel = 0; have = 1'b0; prev_stalled = 1'b0; prev_out = '0;
        d = '0; c = '0; ce = 1'b0;
        while ((idx < n_words || q.size() > 0) && cyc < 4000) begin
            @(posedge clk); #1;
            if (prev_stalled) begin
                n_total++; if ({out_valid, out_data, out_sbe, out_dbe, out_syndrome} !== prev_out)
                    $display("FAIL %s_hold c%0d: got %h want %h", tag, cyc,
                             {out_valid, out_data, out_sbe, out_dbe, out_syndrome}, prev_out); else n_pass++;
            end
            n_total++; if (sbe_cnt !== 2'(m_sbe) || dbe_cnt !== 2'(m_dbe))
                $display("FAIL %s_counters c%0d: got sbe=%0d dbe=%0d want sbe=%0d dbe=%0d",
                         tag, cyc, sbe_cnt, dbe_cnt, m_sbe, m_dbe); else n_pass++;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc < 5);
            cnt_clr   = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
            if (!have && idx < n_words && (!rnd || $urandom_range(0, 4) != 0)) begin
                k = $urandom_range(0, 9);
                gen_word((k < 3) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : -1, d, c);
                ce = 1'($urandom_range(0, 3) != 0);
                have = 1'b1;
            end
            in_valid = have;
            in_data  = have ? d : DW'($urandom);
            in_chk   = have ? c : CW'($urandom);
            corr_en  = have ? ce : 1'($urandom);
            #1;
            n_total++; if (in_ready !== (!out_valid || out_ready))
                $display("FAIL %s_in_ready c%0d: got %b want %b", tag, cyc, in_ready, !out_valid || out_ready); else n_pass++;
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) $display("FAIL %s_extra_word c%0d: got %h want none", tag, cyc, out_data);
                else begin
                    e = q.pop_front();
                    if ({out_data, out_sbe, out_dbe, out_syndrome} !== e)
                        $display("FAIL %s_word%0d: got %h want %h", tag, ndel,
                                 {out_data, out_sbe, out_dbe, out_syndrome}, e);
                    else n_pass++;
                end
                ndel++;
            end
            cnt_model(out_valid && out_ready, out_sbe, out_dbe, cnt_clr);
            if (in_valid && in_ready) begin
                q.push_back(model(d, c, ce));
                idx++;
                have = 1'b0;
            end
            prev_stalled = out_valid && !out_ready;
            prev_out = {out_valid, out_data, out_sbe, out_dbe, out_syndrome};
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        @(posedge clk); #1;
        n_total++; if (ndel !== n_words || q.size() !== 0)
            $display("FAIL %s_delivered: got %0d (pending %0d) want %0d", tag, ndel, q.size(), n_words); else n_pass++;
        n_total++; if (sbe_cnt !== 2'(m_sbe) || dbe_cnt !== 2'(m_dbe))
            $display("FAIL %s_final_counters: got sbe=%0d dbe=%0d want sbe=%0d dbe=%0d",
                     tag, sbe_cnt, dbe_cnt, m_sbe, m_dbe); else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_stream(4, 1'b0, "b2b");
    endtask

    task automatic test_random();
        test_stream(150, 1'b1, "rand");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
